// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit sequencer.
// Holds the md_op encoding and the default latencies. The MADD/MADDU
// codes exist in the encoding in every build. The datapath only accepts
// them when MDU_MADD_EN is defined.
package mdu_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MADD  = 4'd7,
        MD_MADDU = 4'd8
    } md_op_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // True for the divide codes, which are the only ones that can hit B==0.
    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_alu.sv
// mdu_alu: combinational result generator for the MDU.
// Produces the 64-bit {res_hi,res_lo} for the multiply/divide codes from A/B,
// and from HI/LO for the accumulate forms when MDU_MADD_EN is defined.
// The divisor is forced to 1 internally on B==0 so that no X reaches the
// result path. The controller discards that result anyway.
module mdu_alu
    import mdu_pkg::*;
(
    input  logic [3:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_by_zero
);

    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        b_safe;
    logic signed [31:0] quo_s;
    logic signed [31:0] rem_s;
    logic [31:0]        quo_u;
    logic [31:0]        rem_u;

    // The low 64 bits of the sign-extended product equal the signed 64-bit product.
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    assign b_safe = (b == 32'd0) ? 32'd1 : b;

    // Signed / and % truncate toward zero, so the remainder takes the dividend's sign.
    assign quo_s = $signed(a) / $signed(b_safe);
    assign rem_s = $signed(a) % $signed(b_safe);
    assign quo_u = a / b_safe;
    assign rem_u = a % b_safe;

    assign div_by_zero = is_div_op(md_op) && (b == 32'd0);

`ifdef MDU_MADD_EN
    logic [63:0] acc_s;
    logic [63:0] acc_u;

    // The accumulate wraps mod 2^64, so signed and unsigned differ only in the product.
    assign acc_s = {hi, lo} + prod_s;
    assign acc_u = {hi, lo} + prod_u;
`else
    logic unused_acc;
    assign unused_acc = ^{hi, lo};
`endif

    // Select the result pair for the requested operation.
    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (md_op)
            MD_MULT:  {res_hi, res_lo} = prod_s;
            MD_MULTU: {res_hi, res_lo} = prod_u;
            MD_DIV: begin
                res_hi = rem_s;
                res_lo = quo_s;
            end
            MD_DIVU: begin
                res_hi = rem_u;
                res_lo = quo_u;
            end
`ifdef MDU_MADD_EN
            MD_MADD:  {res_hi, res_lo} = acc_s;
            MD_MADDU: {res_hi, res_lo} = acc_u;
`endif
            default: begin
                res_hi = 32'd0;
                res_lo = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: sequencer for the multi-cycle multiply/divide unit in E stage.
// On a start pulse in IDLE (cnt==0), it latches the computed result and
// counts a fixed latency. On the last busy cycle it commits the result to
// HI/LO. MTHI/MTLO write immediately. md_stall holds a D-stage MDU
// instruction while the unit is busy or starting.
// Optional feature macro: MDU_MADD_EN. When it is defined, MADD and MADDU
// are accepted with the multiply latency.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        md_inst_D,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        md_stall
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      res_hi_q, res_hi_d;
    logic [31:0]      res_lo_q, res_lo_d;
    logic             dbz_q, dbz_d;

    logic [31:0]      alu_hi;
    logic [31:0]      alu_lo;
    logic             alu_dbz;

    mdu_alu u_alu (
        .md_op       (md_op),
        .a           (A),
        .b           (B),
        .hi          (hi_q),
        .lo          (lo_q),
        .res_hi      (alu_hi),
        .res_lo      (alu_lo),
        .div_by_zero (alu_dbz)
    );

    // Next-state logic: accept an op in IDLE, count down in RUN, commit on the last count.
    always_comb begin
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        dbz_d    = dbz_q;
        if (cnt_q == '0) begin
            if (start) begin
                case (md_op)
                    MD_MULT, MD_MULTU: begin
                        cnt_d    = CNT_W'(MULT_CYCLES);
                        res_hi_d = alu_hi;
                        res_lo_d = alu_lo;
                        dbz_d    = 1'b0;
                    end
`ifdef MDU_MADD_EN
                    MD_MADD, MD_MADDU: begin
                        cnt_d    = CNT_W'(MULT_CYCLES);
                        res_hi_d = alu_hi;
                        res_lo_d = alu_lo;
                        dbz_d    = 1'b0;
                    end
`endif
                    MD_DIV, MD_DIVU: begin
                        cnt_d    = CNT_W'(DIV_CYCLES);
                        res_hi_d = alu_hi;
                        res_lo_d = alu_lo;
                        dbz_d    = alu_dbz;
                    end
                    MD_MTHI: hi_d = A;
                    MD_MTLO: lo_d = A;
                    default: ;
                endcase
            end
        end else begin
            // A start here is ignored. The stall keeps a well-formed pipeline from issuing one.
            cnt_d = cnt_q - 1'b1;
            if ((cnt_q == CNT_W'(1)) && !dbz_q) begin
                hi_d = res_hi_q;
                lo_d = res_lo_q;
            end
        end
    end

    // State registers. Reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
            dbz_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy     = (cnt_q != '0);
    assign HI       = hi_q;
    assign LO       = lo_q;
    assign md_stall = (busy | start) & md_inst_D;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed bench for mdu_ctrl with a behavioural HI/LO model.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        md_inst_D;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        md_stall;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 0;

    // model state: architectural HI/LO, remaining busy cycles, pending result
    logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
    int          m_left = 0;
    bit          p_skip = 0;

    mdu_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .md_op     (md_op),
        .A         (A),
        .B         (B),
        .md_inst_D (md_inst_D),
        .busy      (busy),
        .HI        (HI),
        .LO        (LO),
        .md_stall  (md_stall)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the spec-level meaning of each op, using native arithmetic.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hi = 0; m_lo = 0; m_left = 0; p_hi = 0; p_lo = 0; p_skip = 0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0 && !p_skip) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (start) begin
            longint          ps;
            longint unsigned pu;
            int              sa, sb;
            sa = A; sb = B;
            ps = longint'(sa) * longint'(sb);
            pu = {32'd0, A} * {32'd0, B};
            p_skip = 0;
            case (md_op)
                4'd1: begin {p_hi, p_lo} = ps; m_left = 5; end
                4'd2: begin {p_hi, p_lo} = pu; m_left = 5; end
                4'd3: begin
                    m_left = 10;
                    if (B == 0) p_skip = 1;
                    else begin p_lo = sa / sb; p_hi = sa % sb; end
                end
                4'd4: begin
                    m_left = 10;
                    if (B == 0) p_skip = 1;
                    else begin p_lo = A / B; p_hi = A % B; end
                end
                4'd5: m_hi = A;
                4'd6: m_lo = A;
`ifdef MDU_MADD_EN
                4'd7: begin {p_hi, p_lo} = {m_hi, m_lo} + ps; m_left = 5; end
                4'd8: begin {p_hi, p_lo} = {m_hi, m_lo} + pu; m_left = 5; end
`endif
                default: ;
            endcase
        end
    end

    // Every-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", {31'd0, busy}, {31'd0, m_left > 0});
            chk("HI", HI, m_hi);
            chk("LO", LO, m_lo);
            chk("md_stall", {31'd0, md_stall}, {31'd0, (m_left > 0 || start) && md_inst_D});
        end
    end

    task automatic op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        start = 1; md_op = o; A = a; B = b;
        @(posedge clk); #1;
        start = 0; md_op = 0;
    endtask

    // Counts busy cycles after an op() returned. The count is bounded.
    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
        if (busy) chk("busy_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int n;
        reset = 1; start = 0; md_op = 0; A = 0; B = 0; md_inst_D = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_HI", HI, 32'd0);
        chk("rst_LO", LO, 32'd0);
        reset = 0;
        cmp_en = 1;

        // reset mid-run
        op(4'd1, 32'd3, 32'd4);
        @(posedge clk); #1;
        reset = 1; #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_HI", HI, 32'd0);
        chk("midrst_LO", LO, 32'd0);
        @(posedge clk); #1;
        reset = 0;
        op(4'd6, 32'd5, 32'd0);
        chk("mtlo_LO", LO, 32'd5);
        chk("mtlo_busy", {31'd0, busy}, 32'd0);

        // MULT -2 * 3
        op(4'd1, 32'hFFFFFFFE, 32'd3);
        count_busy(n);
        chk("mult_cycles", n, 32'd5);
        chk("mult_HI", HI, 32'hFFFFFFFF);
        chk("mult_LO", LO, 32'hFFFFFFFA);

        // MULTU same operands
        op(4'd2, 32'hFFFFFFFE, 32'd3);
        count_busy(n);
        chk("multu_cycles", n, 32'd5);
        chk("multu_HI", HI, 32'h00000002);
        chk("multu_LO", LO, 32'hFFFFFFFA);

        // DIV -7 / 2
        op(4'd3, 32'hFFFFFFF9, 32'd2);
        count_busy(n);
        chk("div_cycles", n, 32'd10);
        chk("div_LO", LO, 32'hFFFFFFFD);
        chk("div_HI", HI, 32'hFFFFFFFF);

        // DIV 7 / -2 -> q=-3, r=1
        op(4'd3, 32'd7, 32'hFFFFFFFE);
        count_busy(n);
        chk("divneg_LO", LO, 32'hFFFFFFFD);
        chk("divneg_HI", HI, 32'd1);

        // DIVU by zero leaves HI/LO unchanged
        op(4'd5, 32'h11, 32'd0);
        op(4'd6, 32'h22, 32'd0);
        op(4'd4, 32'd100, 32'd0);
        count_busy(n);
        chk("dbz_cycles", n, 32'd10);
        chk("dbz_HI", HI, 32'h11);
        chk("dbz_LO", LO, 32'h22);

        // NONE, an out-of-range code, and MADD (unknown unless enabled)
        op(4'd0, 32'd9, 32'd9);
        op(4'hF, 32'd9, 32'd9);
        chk("none_busy", {31'd0, busy}, 32'd0);
        chk("none_HI", HI, 32'h11);
        chk("none_LO", LO, 32'h22);
        op(4'd7, 32'd2, 32'd3);
        count_busy(n);
`ifdef MDU_MADD_EN
        chk("madd_LO", LO, 32'h28);
        chk("madd_HI", HI, 32'h11);
`else
        chk("madd_off_cycles", n, 32'd0);
        chk("madd_off_LO", LO, 32'h22);
`endif

        // stall across a DIV, with a stray start injected mid-busy
        md_inst_D = 1;
        @(posedge clk); #1;
        start = 1; md_op = 4'd3; A = 32'd1000; B = 32'd7;
        #1 chk("stall_start", {31'd0, md_stall}, 32'd1);
        @(posedge clk); #1;
        start = 0; md_op = 0;
        n = 0;
        while (busy && n < 40) begin
            chk("stall_busy", {31'd0, md_stall}, 32'd1);
            if (n == 4) begin start = 1; md_op = 4'd1; A = 32'd9; B = 32'd9; end
            else begin start = 0; md_op = 0; end
            n++;
            @(posedge clk); #1;
        end
        start = 0; md_op = 0;
        #1;
        chk("stall_cycles", n, 32'd10);
        chk("stall_release", {31'd0, md_stall}, 32'd0);
        chk("inject_LO", LO, 32'd142);
        chk("inject_HI", HI, 32'd6);
        md_inst_D = 0;

        repeat (3) @(posedge clk);
        #1;
        cmp_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
